freq_div_ctrl: RTL and testbench
================================

Name: freq_div_ctrl

Overview:
Programmable frequency-divider controller for the lab clocking datapath. Accepts a divide ratio and burst length through a valid/ready config port, then sequences an internal 8-bit wrap counter under start/stop control. Produces a 1-cycle tick enable and a toggling divided clock. Downstream blocks use tick as a clock enable; the core is never clocked by clk_out.

Parameters:
CNT_W, 8, width of divide counter and cfg_div
BURST_W, 8, width of burst tick counter and cfg_burst

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  asynchronous, active-low reset; asserting low clears all state immediately
cfg_valid  in  1  config offer
cfg_ready  out  1  config accept; handshake completes when cfg_valid & cfg_ready at posedge
cfg_div  in  CNT_W  tick period minus 1 (0 -> tick every cycle, 255 -> every 256)
cfg_burst  in  BURST_W  ticks per run; 0 = continuous
start  in  1  begin run (honoured in ARMED only)
stop  in  1  abort run (honoured in RUN only)
tick  out  1  registered 1-cycle pulse at each counter wrap
clk_out  out  1  registered, toggles on every tick; period 2*(div+1) cycles
busy  out  1  high while in RUN
done  out  1  1-cycle pulse when a finite burst completes
cnt  out  CNT_W  live counter value, for debug/observation

Behaviour:
- Reset (rst=0): state=IDLE, cnt=0, div_reg=255, burst_reg=0, tick_cnt=0, tick=0, clk_out=0, busy=0, done=0, cfg_ready=1.
- States: IDLE, ARMED, RUN, DONE (2-bit encoding).
- cfg_ready=1 in IDLE and ARMED, 0 in RUN and DONE. On handshake: div_reg<=cfg_div, burst_reg<=cfg_burst; next state ARMED. A handshake in ARMED overwrites the config.
- IDLE: start ignored. ARMED: start=1 -> RUN; cnt<=0, tick_cnt<=0, clk_out<=0. A start coincident with a cfg handshake uses the new config, since it is loaded on the same edge.
- RUN: cnt increments each cycle. When cnt==div_reg: cnt<=0, tick<=1, clk_out<=~clk_out, tick_cnt<=tick_cnt+1; otherwise tick<=0.
- Latency: if start is sampled at edge E, the first tick is high in the cycle after edge E+div+1. Subsequent ticks are spaced exactly div+1 cycles apart.
- Burst: if burst_reg!=0 and the wrap produces tick number burst_reg, then state<=DONE on that same edge and the final tick is still issued. burst_reg=0 runs until stop; tick_cnt wraps silently at 2^BURST_W.
- DONE: one cycle. done=1, tick=0, cnt=0, clk_out<=0. Next state ARMED with config retained, so start can re-run without reconfiguration.
- stop in RUN: next state ARMED; cnt<=0, tick<=0, clk_out<=0, no done pulse.
- stop and start asserted together: stop wins in RUN, start wins in ARMED, because each is honoured only in its own state.
- stop on the same edge as the final burst wrap: stop wins. No tick, no done, next state ARMED.
- Async reset mid-RUN: outputs clear within the reset assertion with no clock needed. The config is lost and returns to div 255, burst 0. The block resumes in IDLE after rst deasserts.
- All outputs are registered except cfg_ready and busy, which are decoded from the state register only (no input paths).

Decomposition:
- Shared package/header `freq_div_defs`: state encodings (S_IDLE=0, S_ARMED=1, S_RUN=2, S_DONE=3), reset divide default 8'd255, width constants.
- Sub-module `div_counter`: CNT_W-bit counter with en, sync clr, terminal input and wrap output, using the same async active-low rst.
- `freq_div_ctrl` holds the FSM, config registers, burst counter and output registers.

Test Plan:
- Reset, then cfg_div=3, cfg_burst=0, start -> tick every 4 cycles; clk_out period 8 cycles; busy=1; first tick 5 cycles after the start edge.
- cfg_div=0, cfg_burst=5, start -> tick high 5 consecutive cycles, done pulse the cycle after the 5th tick, then ARMED with cfg_ready=1.
- Re-issue start after done with no reconfig -> identical 5-tick burst; cfg_valid during RUN -> cfg_ready=0 and registers unchanged.
- cfg_div=9, continuous, stop asserted with cnt=4 -> next cycle busy=0, cnt=0, clk_out=0, no tick, no done.
- cfg_div=2, burst=2, stop on the edge of the 2nd wrap -> no 2nd tick, no done, state ARMED.
- Pull rst low mid-RUN between clock edges -> tick, clk_out, busy and cnt go to 0 immediately. After release, start with no config is ignored (IDLE). Then config load followed by start runs at the new ratio.

Source files
------------

// File: rtl/freq_div_ctrl_pkg.sv
// Shared definitions for the programmable frequency-divider controller.
package freq_div_ctrl_pkg;

  localparam int CNT_W   = 8;
  localparam int BURST_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Out of reset the divider runs at its slowest ratio (all ones, 255 for 8 bits).
  function automatic logic [CNT_W-1:0] div_rst_val();
    return {CNT_W{1'b1}};
  endfunction

endpackage

// File: rtl/freq_div_ctrl_if.sv
// Config handshake, run control and tick outputs of the divider controller.
interface freq_div_ctrl_if #(
  parameter int CNT_W   = freq_div_ctrl_pkg::CNT_W,
  parameter int BURST_W = freq_div_ctrl_pkg::BURST_W
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [CNT_W-1:0]   cfg_div;
  logic [BURST_W-1:0] cfg_burst;
  logic               start;
  logic               stop;
  logic               tick;
  logic               clk_out;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   cnt;

  modport master (
    output cfg_valid, cfg_div, cfg_burst, start, stop,
    input  cfg_ready, tick, clk_out, busy, done, cnt
  );

  modport slave (
    input  cfg_valid, cfg_div, cfg_burst, start, stop,
    output cfg_ready, tick, clk_out, busy, done, cnt
  );
endinterface

// File: rtl/freq_div_ctrl_div_counter.sv
// Wrap counter: counts 0..term_i while enabled, flags the terminal cycle.
module div_counter
  import freq_div_ctrl_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] term_i,
  output logic         wrap_o,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign wrap_o = en_i && (cnt_q == term_i);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/freq_div_ctrl.sv
// Divider controller: config capture, IDLE/ARMED/RUN/DONE sequencing, burst
// counting and registered tick / clk_out / done outputs.
module freq_div_ctrl
  import freq_div_ctrl_pkg::*;
#(
  parameter int CNT_W   = freq_div_ctrl_pkg::CNT_W,
  parameter int BURST_W = freq_div_ctrl_pkg::BURST_W
) (
  input  logic           clk,
  input  logic           rst,
  freq_div_ctrl_if.slave dif
);

  state_e             state_q;
  logic [CNT_W-1:0]   div_q;
  logic [BURST_W-1:0] burst_q, tick_cnt_q, tick_cnt_d;
  logic               tick_q, clk_out_q, done_q;
  logic               hs, run, wrap, last;
  logic [CNT_W-1:0]   cnt;

  assign run        = (state_q == S_RUN);
  assign hs         = dif.cfg_valid && dif.cfg_ready;
  assign tick_cnt_d = tick_cnt_q + 1'b1;
  assign last       = (burst_q != '0) && (tick_cnt_d == burst_q);

  // Counter is held at zero outside RUN and on the stop edge.
  div_counter #(.W(CNT_W)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .en_i   (run),
    .clr_i  (!run || dif.stop),
    .term_i (div_q),
    .wrap_o (wrap),
    .cnt_o  (cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      div_q      <= div_rst_val();
      burst_q    <= '0;
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
      clk_out_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      done_q <= 1'b0;
      // Config lands on the same edge as a start, so the run sees it at once.
      if (hs) begin
        div_q   <= dif.cfg_div;
        burst_q <= dif.cfg_burst;
      end
      case (state_q)
        S_IDLE: if (hs) state_q <= S_ARMED;
        S_ARMED: begin
          if (dif.start) begin
            state_q    <= S_RUN;
            tick_cnt_q <= '0;
            clk_out_q  <= 1'b0;
          end
        end
        S_RUN: begin
          if (dif.stop) begin
            state_q   <= S_ARMED;
            clk_out_q <= 1'b0;
          end else if (wrap) begin
            tick_q     <= 1'b1;
            clk_out_q  <= ~clk_out_q;
            tick_cnt_q <= tick_cnt_d;
            if (last) state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q   <= S_ARMED;
          done_q    <= 1'b1;
          clk_out_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dif.cfg_ready = (state_q == S_IDLE) || (state_q == S_ARMED);
  assign dif.busy      = run;
  assign dif.tick      = tick_q;
  assign dif.clk_out   = clk_out_q;
  assign dif.done      = done_q;
  assign dif.cnt       = cnt;

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Bench for freq_div_ctrl: table of config/run vectors plus hand-written
// stop, re-run and async-reset sequences; ticks/done checked via scoreboard.
module tb_freq_div_ctrl;
  import freq_div_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  freq_div_ctrl_if #(.CNT_W(8), .BURST_W(8)) dif ();

  freq_div_ctrl #(.CNT_W(8), .BURST_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .dif (dif.slave)
  );

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int   e;
    logic co;
  } tick_exp_t;

  tick_exp_t tq[$];
  int        dq[$];

  typedef struct {
    int div;
    int burst;
    bit same_edge;
    int stop_at;
    int ticks;
    int done_off;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  // Scoreboard side: every observed tick/done must match the next expectation.
  initial begin
    tick_exp_t t;
    int        d;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        if (dif.tick) begin
          if (tq.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_tick: got tick=1 expected none (edge %0d)", edge_n);
          end else begin
            t = tq.pop_front();
            chk("tick_edge", edge_n, t.e);
            chk("clk_out_at_tick", dif.clk_out, t.co);
          end
        end
        if (dif.done) begin
          if (dq.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_done: got done=1 expected none (edge %0d)", edge_n);
          end else begin
            d = dq.pop_front();
            chk("done_edge", edge_n, d);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_to(input int t);
    while (edge_n < t) step(1);
  endtask

  task automatic load_cfg(input int div, input int burst);
    dif.cfg_valid = 1'b1;
    dif.cfg_div   = 8'(div);
    dif.cfg_burst = 8'(burst);
    chk("cfg_ready_on_load", dif.cfg_ready, 1);
    step(1);
    dif.cfg_valid = 1'b0;
  endtask

  task automatic do_start(input int div, input int burst, input bit with_cfg, output int e0);
    dif.start = 1'b1;
    if (with_cfg) begin
      dif.cfg_valid = 1'b1;
      dif.cfg_div   = 8'(div);
      dif.cfg_burst = 8'(burst);
      chk("cfg_ready_with_start", dif.cfg_ready, 1);
    end
    e0 = edge_n + 1;
    step(1);
    dif.start     = 1'b0;
    dif.cfg_valid = 1'b0;
    chk("busy_after_start", dif.busy, 1);
  endtask

  task automatic push_ticks(input int e0, input int div, input int n);
    for (int i = 1; i <= n; i++) tq.push_back('{e0 + (div + 1) * i, (i % 2) == 1});
  endtask

  task automatic run_vec(input vec_t v);
    int e0;
    if (!v.same_edge) load_cfg(v.div, v.burst);
    do_start(v.div, v.burst, v.same_edge, e0);
    push_ticks(e0, v.div, v.ticks);
    if (v.done_off != 0) dq.push_back(e0 + v.done_off);
    if (v.stop_at != 0) begin
      wait_to(e0 + v.stop_at - 1);
      dif.stop = 1'b1;
      step(1);
      dif.stop = 1'b0;
      chk("stop_busy", dif.busy, 0);
      chk("stop_clk_out", dif.clk_out, 0);
      chk("stop_tick", dif.tick, 0);
    end else begin
      wait_to(e0 + v.done_off);
      chk("after_done_cfg_ready", dif.cfg_ready, 1);
      chk("after_done_busy", dif.busy, 0);
    end
    step(2);
    chk("idle_cnt", dif.cnt, 0);
    chk("ticks_outstanding", tq.size(), 0);
    chk("done_outstanding", dq.size(), 0);
  endtask

  initial begin
    int e0;
    vecs[0] = '{div: 3,   burst: 0, same_edge: 0, stop_at: 18, ticks: 4, done_off: 0};
    vecs[1] = '{div: 0,   burst: 5, same_edge: 0, stop_at: 0,  ticks: 5, done_off: 6};
    vecs[2] = '{div: 2,   burst: 3, same_edge: 1, stop_at: 0,  ticks: 3, done_off: 10};
    vecs[3] = '{div: 255, burst: 1, same_edge: 1, stop_at: 0,  ticks: 1, done_off: 257};
    vecs[4] = '{div: 1,   burst: 0, same_edge: 0, stop_at: 7,  ticks: 3, done_off: 0};
    vecs[5] = '{div: 7,   burst: 2, same_edge: 0, stop_at: 0,  ticks: 2, done_off: 17};

    dif.cfg_valid = 1'b0;
    dif.cfg_div   = '0;
    dif.cfg_burst = '0;
    dif.start     = 1'b0;
    dif.stop      = 1'b0;

    step(3);
    chk("rst_cfg_ready", dif.cfg_ready, 1);
    chk("rst_busy", dif.busy, 0);
    chk("rst_tick", dif.tick, 0);
    chk("rst_clk_out", dif.clk_out, 0);
    chk("rst_done", dif.done, 0);
    chk("rst_cnt", dif.cnt, 0);
    rst = 1'b1;
    step(1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Re-run retained config (div 7, burst 2); config offers during RUN refused.
    do_start(0, 0, 1'b0, e0);
    push_ticks(e0, 7, 2);
    dq.push_back(e0 + 17);
    for (int k = 0; k < 12; k++) begin
      dif.cfg_valid = 1'b1;
      dif.cfg_div   = 8'd0;
      dif.cfg_burst = 8'd1;
      chk("cfg_ready_in_run", dif.cfg_ready, 0);
      step(1);
    end
    dif.cfg_valid = 1'b0;
    wait_to(e0 + 17);
    chk("rerun_armed", dif.cfg_ready, 1);
    step(2);

    // Continuous div 9, stop with cnt at 4 after the first tick.
    load_cfg(9, 0);
    do_start(9, 0, 1'b0, e0);
    push_ticks(e0, 9, 1);
    wait_to(e0 + 14);
    chk("cnt_before_stop", dif.cnt, 4);
    chk("clk_out_before_stop", dif.clk_out, 1);
    dif.stop = 1'b1;
    step(1);
    dif.stop = 1'b0;
    chk("stop9_busy", dif.busy, 0);
    chk("stop9_cnt", dif.cnt, 0);
    chk("stop9_clk_out", dif.clk_out, 0);
    chk("stop9_tick", dif.tick, 0);
    chk("stop9_done", dif.done, 0);
    step(12);

    // Stop on the final burst wrap: no second tick, no done, back to ARMED.
    load_cfg(2, 2);
    do_start(2, 2, 1'b0, e0);
    push_ticks(e0, 2, 1);
    wait_to(e0 + 5);
    dif.stop = 1'b1;
    step(1);
    dif.stop = 1'b0;
    chk("lastwrap_stop_tick", dif.tick, 0);
    chk("lastwrap_stop_busy", dif.busy, 0);
    chk("lastwrap_stop_ready", dif.cfg_ready, 1);
    step(3);
    do_start(2, 2, 1'b0, e0);
    push_ticks(e0, 2, 2);
    dq.push_back(e0 + 7);
    wait_to(e0 + 7);
    step(2);

    // Async reset between edges mid-RUN.
    load_cfg(3, 0);
    do_start(3, 0, 1'b0, e0);
    push_ticks(e0, 3, 1);
    wait_to(e0 + 6);
    chk("pre_rst_cnt", dif.cnt, 2);
    chk("pre_rst_clk_out", dif.clk_out, 1);
    #3;
    rst = 1'b0;
    #1;
    chk("async_rst_tick", dif.tick, 0);
    chk("async_rst_clk_out", dif.clk_out, 0);
    chk("async_rst_busy", dif.busy, 0);
    chk("async_rst_cnt", dif.cnt, 0);
    step(2);
    rst = 1'b1;
    step(1);
    dif.start = 1'b1;
    step(1);
    dif.start = 1'b0;
    step(8);
    chk("idle_start_ignored", dif.busy, 0);
    chk("idle_cfg_ready", dif.cfg_ready, 1);
    load_cfg(1, 2);
    do_start(1, 2, 1'b0, e0);
    push_ticks(e0, 1, 2);
    dq.push_back(e0 + 5);
    wait_to(e0 + 5);
    step(3);

    chk("final_ticks_outstanding", tq.size(), 0);
    chk("final_done_outstanding", dq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_err);
    $finish;
  end

endmodule
